// File: rtl/io_bridge_pkg.sv
// io_bridge_pkg
// Shared constants for the memory-mapped I/O bridge: register offsets
// (selected by address[4:3]), switch/LED widths and the default window base.
package io_bridge_pkg;

   localparam int SW_W  = 18;
   localparam int LED_W = 27;

   localparam logic [63:0] IO_BASE_DEFAULT = 64'h0000_0000_0000_1000;

   // Register select, taken from address[4:3] (doubleword registers).
   typedef enum logic [1:0] {
      IO_SWITCH = 2'd0,
      IO_LED    = 2'd1,
      IO_CYCLE  = 2'd2,
      IO_EDGE   = 2'd3
   } io_reg_e;

endpackage

// File: rtl/io_bridge_switch_debouncer.sv
// switch_debouncer
// Two-flop synchroniser followed by a vector-wide debouncer. A single counter
// covers the whole vector: any change in the synchronised value restarts it,
// and the candidate is accepted once it has been steady for DEBOUNCE_CYCLES.
// Ports:
//   clock, reset   core clock, async active-high reset
//   sw_i           raw switches, asynchronous to clock
//   stable_o       accepted (debounced) switch value
//   stable_next_o  value stable_o takes at the next edge
//   update_o       one-cycle strobe: stable_o changes at the next edge
module switch_debouncer #(
   parameter int W               = 18,
   parameter int DEBOUNCE_CYCLES = 65536
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [W-1:0] sw_i,
   output logic [W-1:0] stable_o,
   output logic [W-1:0] stable_next_o,
   output logic         update_o
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [W-1:0]     sync1_q, sync2_q;
   logic [W-1:0]     cand_q, stable_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]     stable_d;
   logic             same;
   logic             accept;

   always_comb begin
      same   = (sync2_q == cand_q);
      accept = same && (cnt_q == CNT_MAX);
      cnt_d  = '0;
      if (same) begin
         cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      end
      stable_d = accept ? cand_q : stable_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         cand_q   <= '0;
         cnt_q    <= '0;
         stable_q <= '0;
      end else begin
         sync1_q  <= sw_i;
         sync2_q  <= sync1_q;
         cand_q   <= sync2_q;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   assign stable_o      = stable_q;
   assign stable_next_o = stable_d;
   // The counter saturates, so acceptance repeats every cycle; only flag real changes.
   assign update_o      = accept && (cand_q != stable_q);

endmodule

// File: rtl/io_bridge.sv
// io_bridge
// Memory-mapped I/O window beside data memory. Decodes the EX/MEM address,
// owns the LED register, a free-running 64-bit cycle counter, debounced
// switches and sticky switch rising-edge flags (write-1-to-clear).
// Ports:
//   clock, reset          core clock, async active-high reset
//   address, write_data   EX/MEM ALU result and store data
//   MemWrite, MemRead     store / load strobes
//   switches              raw board switches (asynchronous)
//   leds                  LED register
//   read_data             load data (combinational, 0 unless an I/O load)
//   is_io                 address lies in the 32-byte I/O window
module io_bridge
   import io_bridge_pkg::*;
#(
   parameter logic [63:0] IO_BASE         = IO_BASE_DEFAULT,
   parameter int          DEBOUNCE_CYCLES = 65536
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [63:0]       address,
   input  logic [63:0]       write_data,
   input  logic              MemWrite,
   input  logic              MemRead,
   input  logic [SW_W-1:0]   switches,
   output logic [LED_W-1:0]  leds,
   output logic [63:0]       read_data,
   output logic              is_io
);

   logic [LED_W-1:0] led_q, led_d;
   logic [63:0]      cycle_q, cycle_d;
   logic [SW_W-1:0]  edge_q, edge_d;
   logic [SW_W-1:0]  sw_stable, sw_stable_next;
   logic             sw_update;
   logic [SW_W-1:0]  edge_clr;
   io_reg_e          reg_sel;
   logic             wr;
   logic             unused_bits;

   assign unused_bits = ^{address[2:0], write_data[63:LED_W], sw_update};

   switch_debouncer #(
      .W               (SW_W),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_deb (
      .clock         (clock),
      .reset         (reset),
      .sw_i          (switches),
      .stable_o      (sw_stable),
      .stable_next_o (sw_stable_next),
      .update_o      (sw_update)
   );

   assign is_io   = (address[63:5] == IO_BASE[63:5]);
   assign reg_sel = io_reg_e'(address[4:3]);
   assign wr      = MemWrite && is_io;

   // Continuous assignment keeps the counter next-state a plain net.
   assign cycle_d = (wr && reg_sel == IO_CYCLE) ? 64'd0 : cycle_q + 64'd1;

   always_comb begin
      led_d    = led_q;
      edge_clr = '0;
      if (wr && reg_sel == IO_LED)  led_d    = write_data[LED_W-1:0];
      if (wr && reg_sel == IO_EDGE) edge_clr = write_data[SW_W-1:0];
      // OR-ing the rise after the clear makes a simultaneous set win.
      edge_d = (edge_q & ~edge_clr) | (sw_stable_next & ~sw_stable);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         led_q   <= '0;
         cycle_q <= '0;
         edge_q  <= '0;
      end else begin
         led_q   <= led_d;
         cycle_q <= cycle_d;
         edge_q  <= edge_d;
      end
   end

   always_comb begin
      read_data = 64'd0;
      if (MemRead && is_io) begin
         case (reg_sel)
            IO_SWITCH: read_data = {{(64-SW_W){1'b0}}, sw_stable};
            IO_LED:    read_data = {{(64-LED_W){1'b0}}, led_q};
            IO_CYCLE:  read_data = cycle_q;
            IO_EDGE:   read_data = {{(64-SW_W){1'b0}}, edge_q};
            default:   read_data = 64'd0;
         endcase
      end
   end

   assign leds = led_q;

endmodule
